// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the pipelined dual-port RAM.
package dp_ram_pkg;

    typedef enum logic {
        READ_FIRST,
        WRITE_FIRST
    } rdw_mode_e;

    typedef enum logic {
        CLEAR,
        RUN
    } clr_state_e;

    localparam int MAX_READ_LATENCY = 4;
    localparam int MAX_DATA_WIDTH   = 256;
    localparam int MAX_IDX_WIDTH    = $clog2(MAX_DATA_WIDTH);

    // Replace every byte lane of old_word whose enable bit is set with new_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_DATA_WIDTH-1:0] be,
        input int                        byte_width
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (be[MAX_IDX_WIDTH'(i / byte_width)]) res[i] = new_word[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read-data delay line: LATENCY registered stages of valid+data; the last
// stage only loads on valid so the output word holds between reads.
module dp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  valid_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_q  [LATENCY];

    // NOTE: pipeline stages are plain registers, so they are reset (unlike the
    // RAM array); sequential state is always assigned with <=.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) data_q[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/dp_ram_pipe.sv
// True dual-port byte-enable RAM with pipelined reads and collision flag.
// Define DP_RAM_CLEAR_EN to zero the array after reset before accepting requests.
module dp_ram_pipe
    import dp_ram_pkg::*;
#(
    parameter int        DATA_WIDTH   = 32,
    parameter int        BYTE_WIDTH   = 8,
    parameter int        MEM_DEPTH    = 1024,
    parameter int        ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int        READ_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE     = READ_FIRST,
    localparam int       NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [NUM_BYTES-1:0]  be_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  rvalid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [NUM_BYTES-1:0]  be_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  rvalid_b,
    output logic                  collision,
    output logic                  ready
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  in_range_a, in_range_b, same_addr, same_wr;
    logic                  rd_a, rd_b, wr_a, wr_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, word_a, word_b;
    logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    assign in_range_a = 32'(addr_a) < MEM_DEPTH;
    assign in_range_b = 32'(addr_b) < MEM_DEPTH;
    assign same_addr  = addr_a == addr_b;

    assign rd_a    = ready & en_a & ~we_a;
    assign rd_b    = ready & en_b & ~we_b;
    assign wr_a    = ready & en_a & we_a & in_range_a;
    assign wr_b    = ready & en_b & we_b & in_range_b;
    assign same_wr = wr_a & wr_b & same_addr;

    assign old_a = in_range_a ? mem[addr_a] : '0;
    assign old_b = in_range_b ? mem[addr_b] : '0;

    // B is merged first so port A's lanes win when both write one word.
    assign word_b = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_b), MAX_DATA_WIDTH'(din_b),
                                           MAX_DATA_WIDTH'(be_b), BYTE_WIDTH));
    assign word_a = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(same_wr ? word_b : old_a),
                                           MAX_DATA_WIDTH'(din_a),
                                           MAX_DATA_WIDTH'(be_a), BYTE_WIDTH));

    assign rd_data_a = !in_range_a ? '0 :
                       (RDW_MODE == WRITE_FIRST && wr_b && same_addr) ? word_b : old_a;
    assign rd_data_b = !in_range_b ? '0 :
                       (RDW_MODE == WRITE_FIRST && wr_a && same_addr) ? word_a : old_b;

    // NOTE: the storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_addr] <= '0;
        if (wr_a) mem[addr_a] <= word_a;
        if (wr_b && !same_wr) mem[addr_b] <= word_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) collision <= 1'b0;
        else     collision <= ready & en_a & en_b & same_addr & (we_a | we_b);
    end

`ifdef DP_RAM_CLEAR_EN
    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        ready      = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) state_d = RUN;
            end
            RUN:     ready = 1'b1;
            default: state_d = CLEAR;
        endcase
    end

    assign clr_addr = clr_addr_q;
`else
    assign ready    = 1'b1;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    dp_ram_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .LATENCY   (READ_LATENCY)
    ) u_rd_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_a),
        .in_data  (rd_data_a),
        .out_valid(rvalid_a),
        .out_data (dout_a)
    );

    dp_ram_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .LATENCY   (READ_LATENCY)
    ) u_rd_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_b),
        .in_data  (rd_data_b),
        .out_valid(rvalid_b),
        .out_data (dout_b)
    );

endmodule
